// File: rtl/key_debounce_array.sv
// Multi-channel key debouncer: 2-flop synchronizer, stability counter, and
// press/release/long-press pulse generation per channel.
module key_debounce_array #(
    parameter int N_KEYS     = 4,
    parameter int CNT_W      = 15,
    parameter int KEEP_TIME  = 3,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_W     = 20,
    parameter int LONG_TIME  = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic              any_press
);

    localparam logic              REL_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0]  KEEP_C   = CNT_W'(KEEP_TIME);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [LONG_W-1:0] LONG_C   = LONG_W'(LONG_TIME);
    localparam logic [LONG_W-1:0] LONG_M1  = LONG_W'(LONG_TIME - 1);
    localparam logic [LONG_W-1:0] HOLD_ONE = LONG_W'(1);

    logic [N_KEYS-1:0] sync1_r;
    logic [N_KEYS-1:0] sync2_r;
    logic [N_KEYS-1:0] s_s;
    logic [N_KEYS-1:0] key_state_r;
    logic [N_KEYS-1:0] key_press_r;
    logic [N_KEYS-1:0] key_release_r;
    logic [N_KEYS-1:0] key_long_r;
    logic [CNT_W-1:0]  cnt_r      [N_KEYS];
    logic [LONG_W-1:0] hold_cnt_r [N_KEYS];

    // Two-flop synchronizer; resets to the released pin level so no false press appears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= {N_KEYS{REL_LVL}};
            sync2_r <= {N_KEYS{REL_LVL}};
        end else begin
            sync1_r <= key_in;
            sync2_r <= sync1_r;
        end
    end

    assign s_s = (ACTIVE_LOW != 0) ? ~sync2_r : sync2_r;

    // Stability counter per channel; any return to the current state restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_state_r   <= {N_KEYS{1'b0}};
            key_press_r   <= {N_KEYS{1'b0}};
            key_release_r <= {N_KEYS{1'b0}};
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                key_press_r[i]   <= 1'b0;
                key_release_r[i] <= 1'b0;
                if (s_s[i] == key_state_r[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] == KEEP_C) begin
                    cnt_r[i]         <= {CNT_W{1'b0}};
                    key_state_r[i]   <= s_s[i];
                    key_press_r[i]   <= s_s[i];
                    key_release_r[i] <= ~s_s[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Hold counter saturates at the threshold, so the long pulse fires once per press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_long_r <= {N_KEYS{1'b0}};
            for (int i = 0; i < N_KEYS; i++) begin
                hold_cnt_r[i] <= {LONG_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                key_long_r[i] <= key_state_r[i] && (hold_cnt_r[i] == LONG_M1);
                if (!key_state_r[i]) begin
                    hold_cnt_r[i] <= {LONG_W{1'b0}};
                end else if (hold_cnt_r[i] < LONG_C) begin
                    hold_cnt_r[i] <= hold_cnt_r[i] + HOLD_ONE;
                end else begin
                    hold_cnt_r[i] <= hold_cnt_r[i];
                end
            end
        end
    end

    assign key_state   = key_state_r;
    assign key_press   = key_press_r;
    assign key_release = key_release_r;
    assign key_long    = key_long_r;
    assign any_press   = |key_press_r;

endmodule
